// File: rtl/pll_reconf_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconf_ctrl
//
// Purpose:
//   Sequences dynamic reconfiguration of an rPLL. A request either selects a
//   new divider preset, which resets and relocks the PLL with retries, or
//   changes only the PSDA phase step, which waits for a settle time. An
//   unexpected loss of lock while idle starts an automatic relock.
//
// Ports:
//   clk        - single clock, all logic in this domain
//   reset      - asynchronous, active-high reset
//   cfg_table  - static preset table, entry k = {idsel, fbdsel, odsel}
//                at bits [18k+17:18k]
//   req        - single-cycle change request (ignored while busy)
//   req_sel    - requested preset index
//   req_phase  - requested PSDA phase step
//   pll_lock   - PLL LOCK output, asynchronous to clk
//   pll_reset  - PLL reset pin
//   pll_idsel, pll_fbdsel, pll_odsel - PLL dynamic divider pins
//   pll_psda   - PLL dynamic phase pins
//   busy       - operation in progress
//   done       - one-cycle pulse when an operation completes
//   fail       - sticky error flag (bad index or lock timeout)
//   locked     - PLL locked with the current preset
//   cur_sel    - preset currently applied to the PLL
// ---------------------------------------------------------------------------
module pll_reconf_ctrl #(
    parameter int NUM_CFG      = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 4,
    parameter int SETTLE       = 8,
    parameter int MAX_RETRY    = 3,
    localparam int SEL_W       = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CFG*18-1:0] cfg_table,
    input  logic                  req,
    input  logic [SEL_W-1:0]      req_sel,
    input  logic [3:0]            req_phase,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic [5:0]            pll_idsel,
    output logic [5:0]            pll_fbdsel,
    output logic [5:0]            pll_odsel,
    output logic [3:0]            pll_psda,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic                  locked,
    output logic [SEL_W-1:0]      cur_sel
);

    // One shared counter serves the RST, WAIT_LOCK and PHASE phases, so it
    // must be wide enough for the longest of them.
    localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES)
                             ? ((LOCK_TIMEOUT > SETTLE) ? LOCK_TIMEOUT : SETTLE)
                             : ((RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [SEL_W:0]   NUM_CFG_L = (SEL_W + 1)'(NUM_CFG);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        WAIT_LOCK,
        PHASE,
        ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [3:0]        psda_q, psda_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic              locked_q, locked_d;
    logic              lock_meta_q, lock_s_q;

    logic [17:0]       cfg_arr [NUM_CFG];
    logic              req_valid;
    logic [RTY_W-1:0]  retry_inc;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        assign cfg_arr[k] = cfg_table[18*k +: 18];
    end

    // The table is static, so the dividers follow the latched preset index
    // directly; they only change on the edge where cur_sel changes.
    assign {pll_idsel, pll_fbdsel, pll_odsel} = cfg_arr[sel_q];
    assign pll_psda  = psda_q;
    assign pll_reset = (state_q == RST);
    assign busy      = (state_q == RST) || (state_q == WAIT_LOCK) || (state_q == PHASE);
    assign done      = done_q;
    assign fail      = fail_q;
    assign locked    = locked_q;
    assign cur_sel   = sel_q;

    assign req_valid = ({1'b0, req_sel} < NUM_CFG_L);
    assign retry_inc = retry_q + RTY_W'(1);

    // Two-flop synchroniser for the asynchronous PLL lock signal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State and datapath registers. Reset parks the controller in RST so the
    // PLL is brought up with preset 0 without any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST;
            cnt_q    <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            sel_q    <= '0;
            psda_q   <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            sel_q    <= sel_d;
            psda_q   <= psda_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    // Next-state logic. A request is examined before lock loss in IDLE so a
    // valid request wins when both happen in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        sel_d    = sel_q;
        psda_d   = psda_q;
        done_d   = 1'b0;
        fail_d   = fail_q;
        locked_d = locked_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!req_valid) begin
                        fail_d = 1'b1;
                    end else if (req_sel != sel_q) begin
                        sel_d    = req_sel;
                        psda_d   = req_phase;
                        retry_d  = '0;
                        fail_d   = 1'b0;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = RST;
                    end else begin
                        psda_d  = req_phase;
                        cnt_d   = '0;
                        state_d = PHASE;
                    end
                end else if (locked_q && !lock_s_q) begin
                    locked_d = 1'b0;
                    retry_d  = '0;
                    cnt_d    = '0;
                    state_d  = RST;
                end
            end

            RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Lock qualification takes precedence over a timeout that
            // expires on the same cycle.
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    stable_d = stable_q + STB_W'(1);
                end else begin
                    stable_d = '0;
                end

                if (lock_s_q && (stable_q == STB_LAST)) begin
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    stable_d = '0;
                    state_d  = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    if (retry_inc < RTY_MAX) begin
                        state_d = RST;
                    end else begin
                        fail_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = ERROR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PHASE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Any valid request restarts, even for the same preset.
            ERROR: begin
                if (req) begin
                    if (!req_valid) begin
                        fail_d = 1'b1;
                    end else begin
                        sel_d    = req_sel;
                        psda_d   = req_phase;
                        retry_d  = '0;
                        fail_d   = 1'b0;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = RST;
                    end
                end
            end

            default: begin
                state_d = RST;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconf_ctrl
//
// Purpose:
//   Directed bench for pll_reconf_ctrl. Instance A (NUM_CFG=4) walks through
//   power-up, preset switch, phase-only change, lock loss with timeouts into
//   ERROR, restart, and request/lock-loss priority. Instance B (NUM_CFG=3)
//   covers an out-of-range preset index. Expected configurations are queued
//   when a request is driven and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_pll_reconf_ctrl;

    localparam int NCFG = 4;
    localparam int RSTC = 4;
    localparam int TO   = 20;
    localparam int STB  = 4;
    localparam int SET  = 8;
    localparam int RTY  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] cfgEntry(input int k);
        cfgEntry = {6'(k + 1), 6'(3 * k + 10), 6'(k + 20)};
    endfunction

    // Instance A signals
    logic        reset, req, pllLock;
    logic [1:0]  reqSel;
    logic [3:0]  reqPhase;
    logic [71:0] cfgTab;
    logic        pllReset, busy, done, fail, locked;
    logic [5:0]  idsel, fbdsel, odsel;
    logic [3:0]  psda;
    logic [1:0]  curSel;

    // Instance B signals
    logic        resetB, reqB, pllLockB;
    logic [1:0]  reqSelB;
    logic [3:0]  reqPhaseB;
    logic [53:0] cfgTabB;
    logic        pllResetB, busyB, doneB, failB, lockedB;
    logic [5:0]  idselB, fbdselB, odselB;
    logic [3:0]  psdaB;
    logic [1:0]  curSelB;

    assign cfgTab  = {cfgEntry(3), cfgEntry(2), cfgEntry(1), cfgEntry(0)};
    assign cfgTabB = {cfgEntry(2), cfgEntry(1), cfgEntry(0)};

    pll_reconf_ctrl #(
        .NUM_CFG(NCFG), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(STB), .SETTLE(SET), .MAX_RETRY(RTY)
    ) dutA (
        .clk(clk), .reset(reset), .cfg_table(cfgTab), .req(req),
        .req_sel(reqSel), .req_phase(reqPhase), .pll_lock(pllLock),
        .pll_reset(pllReset), .pll_idsel(idsel), .pll_fbdsel(fbdsel),
        .pll_odsel(odsel), .pll_psda(psda), .busy(busy), .done(done),
        .fail(fail), .locked(locked), .cur_sel(curSel)
    );

    pll_reconf_ctrl #(
        .NUM_CFG(3), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(STB), .SETTLE(SET), .MAX_RETRY(RTY)
    ) dutB (
        .clk(clk), .reset(resetB), .cfg_table(cfgTabB), .req(reqB),
        .req_sel(reqSelB), .req_phase(reqPhaseB), .pll_lock(pllLockB),
        .pll_reset(pllResetB), .pll_idsel(idselB), .pll_fbdsel(fbdselB),
        .pll_odsel(odselB), .pll_psda(psdaB), .busy(busyB), .done(doneB),
        .fail(failB), .locked(lockedB), .cur_sel(curSelB)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [17:0] div;
        logic [3:0]  psda;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input int ph);
        reqSel   = 2'(sel);
        reqPhase = 4'(ph);
        req      = 1'b1;
        step();
        req      = 1'b0;
    endtask

    task automatic pushExp(input int sel, input int ph);
        sbQ.push_back({2'(sel), cfgEntry(sel), 4'(ph)});
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, done, 1);
        step();
        checkOutput({tag, "_pulse"}, done, 0);
        checkOutput({tag, "_locked"}, locked, 1);
    endtask

    // Scoreboard: every done pulse of instance A must match a queued request.
    always @(negedge clk) begin : sbMonitor
        exp_t e;
        if (reset === 1'b0 && done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_done", sbQ.size(), 1);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_cur_sel", curSel, e.sel);
                checkOutput("sb_dividers", {idsel, fbdsel, odsel}, e.div);
                checkOutput("sb_psda", psda, e.psda);
                checkOutput("sb_locked", locked, 1);
            end
        end
    end

    initial begin
        int n;
        int rstCnt;
        int rstSeen;

        reset = 1'b1; req = 1'b0; reqSel = '0; reqPhase = '0; pllLock = 1'b0;
        resetB = 1'b1; reqB = 1'b0; reqSelB = '0; reqPhaseB = '0; pllLockB = 1'b0;
        repeat (3) step();

        // Reset state
        checkOutput("rst_pll_reset", pllReset, 1);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_cur_sel", curSel, 0);
        checkOutput("rst_psda", psda, 0);
        checkOutput("rst_dividers", {idsel, fbdsel, odsel}, cfgEntry(0));

        // Power-up: pulse completes, lock arrives 10 cycles after release
        reset = 1'b0;
        n = 0;
        while (pllReset === 1'b1 && n < 50) begin
            step();
            n++;
        end
        checkOutput("por_reset_len", n, RSTC);
        checkOutput("por_busy_wait", busy, 1);
        repeat (10 - RSTC) step();
        pllLock = 1'b1;
        pushExp(0, 0);
        waitDone("por_done", 40);
        checkOutput("por_cur_sel", curSel, 0);

        // Preset switch
        pushExp(2, 5);
        applyStimulus(2, 5);
        checkOutput("sw_cur_sel", curSel, 2);
        checkOutput("sw_dividers", {idsel, fbdsel, odsel}, cfgEntry(2));
        checkOutput("sw_psda", psda, 5);
        checkOutput("sw_busy", busy, 1);
        n = 0;
        while (pllReset === 1'b1 && n < 50) begin
            step();
            n++;
        end
        checkOutput("sw_reset_len", n, RSTC);
        waitDone("sw_done", 40);

        // Phase-only change
        pushExp(2, 9);
        applyStimulus(2, 9);
        checkOutput("ph_psda", psda, 9);
        checkOutput("ph_busy", busy, 1);
        checkOutput("ph_no_reset", pllReset, 0);
        checkOutput("ph_dividers", {idsel, fbdsel, odsel}, cfgEntry(2));
        n = 0;
        rstSeen = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
            if (pllReset === 1'b1) rstSeen = 1;
        end
        checkOutput("ph_settle_len", n, SET);
        checkOutput("ph_done", done, 1);
        checkOutput("ph_reset_seen", rstSeen, 0);
        step();
        checkOutput("ph_done_pulse", done, 0);
        checkOutput("ph_locked", locked, 1);

        // Lock loss while idle, then lock held low until ERROR
        pllLock = 1'b0;
        n = 0;
        while (pllReset !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checkOutput("loss_latency", n, 3);
        checkOutput("loss_locked", locked, 0);
        checkOutput("loss_cur_sel", curSel, 2);
        n = 0;
        rstCnt = 1;
        while (fail !== 1'b1 && n < 200) begin
            step();
            n++;
            if (pllReset === 1'b1) rstCnt++;
        end
        checkOutput("to_total_len", n, RTY * (RSTC + TO));
        checkOutput("to_reset_cycles", rstCnt, RTY * RSTC);
        checkOutput("err_busy", busy, 0);
        checkOutput("err_pll_reset", pllReset, 0);
        checkOutput("err_locked", locked, 0);
        repeat (5) step();
        checkOutput("err_fail_sticky", fail, 1);

        // Restart from ERROR
        pushExp(1, 3);
        applyStimulus(1, 3);
        checkOutput("rs_fail_clr", fail, 0);
        checkOutput("rs_cur_sel", curSel, 1);
        checkOutput("rs_dividers", {idsel, fbdsel, odsel}, cfgEntry(1));
        checkOutput("rs_pll_reset", pllReset, 1);
        pllLock = 1'b1;
        waitDone("rs_done", 60);

        // Preset 3 accepted; a request while busy is dropped
        pushExp(3, 6);
        applyStimulus(3, 6);
        checkOutput("s3_cur_sel", curSel, 3);
        step();
        applyStimulus(0, 1);
        checkOutput("busy_ignore_sel", curSel, 3);
        checkOutput("busy_ignore_psda", psda, 6);
        waitDone("s3_done", 60);

        // Valid request coincides with lock loss: request wins
        pllLock = 1'b0;
        step();
        step();
        pushExp(0, 4);
        applyStimulus(0, 4);
        checkOutput("prio_cur_sel", curSel, 0);
        checkOutput("prio_psda", psda, 4);
        checkOutput("prio_dividers", {idsel, fbdsel, odsel}, cfgEntry(0));
        checkOutput("prio_pll_reset", pllReset, 1);
        pllLock = 1'b1;
        waitDone("prio_done", 60);

        // Instance B: out-of-range index with NUM_CFG=3
        resetB = 1'b0;
        pllLockB = 1'b1;
        n = 0;
        while (doneB !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        checkOutput("b_up_done", doneB, 1);
        step();
        checkOutput("b_up_locked", lockedB, 1);
        reqSelB = 2'd3; reqPhaseB = 4'd7; reqB = 1'b1;
        step();
        reqB = 1'b0;
        checkOutput("b_bad_fail", failB, 1);
        checkOutput("b_bad_busy", busyB, 0);
        checkOutput("b_bad_cur_sel", curSelB, 0);
        checkOutput("b_bad_psda", psdaB, 0);
        checkOutput("b_bad_pll_reset", pllResetB, 0);
        checkOutput("b_bad_done", doneB, 0);
        repeat (3) step();
        checkOutput("b_bad_idle", busyB, 0);
        checkOutput("b_bad_fail_sticky", failB, 1);
        reqSelB = 2'd1; reqPhaseB = 4'd2; reqB = 1'b1;
        step();
        reqB = 1'b0;
        checkOutput("b_good_fail_clr", failB, 0);
        checkOutput("b_good_cur_sel", curSelB, 1);
        checkOutput("b_good_dividers", {idselB, fbdselB, odselB}, cfgEntry(1));

        checkOutput("sb_empty", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reconf_ctrl.md
PLL_RECONF_CTRL -- requirements
Module: pll_reconf_ctrl

Interface
REQ-001 SHALL have parameter NUM_CFG, default 4: number of divider presets, range 1..16.
REQ-002 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in clk cycles, at least 2.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum clk cycles spent in WAIT_LOCK.
REQ-004 SHALL have parameter LOCK_STABLE, default 4: consecutive synchronised lock-high cycles needed to declare lock.
REQ-005 SHALL have parameter SETTLE, default 8: wait in clk cycles after a phase-only change.
REQ-006 SHALL have parameter MAX_RETRY, default 3: lock attempts before entering ERROR.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port cfg_table, input, NUM_CFG*18 bits: entry k is {idsel[5:0], fbdsel[5:0], odsel[5:0]} at bits [18k+17:18k]; it is static.
REQ-010 SHALL have port req, input, 1 bit: single-cycle change request.
REQ-011 SHALL have port req_sel, input, max(1,clog2(NUM_CFG)) bits: requested preset index.
REQ-012 SHALL have port req_phase, input, 4 bits: requested PSDA phase step.
REQ-013 SHALL have port pll_lock, input, 1 bit: PLL LOCK output, asynchronous to clk.
REQ-014 SHALL have ports pll_reset (output, 1 bit), pll_idsel, pll_fbdsel and pll_odsel (outputs, 6 bits each), and pll_psda (output, 4 bits); these drive the rPLL dynamic pins.
REQ-015 SHALL have outputs busy (1 bit), done (1 bit, one-cycle pulse), fail (1 bit, sticky), locked (1 bit) and cur_sel (req_sel width).

Function
REQ-016 SHALL pass pll_lock through a 2-flop synchroniser (lock_s) before any use.
REQ-017 SHALL implement the states IDLE, RST, WAIT_LOCK, PHASE and ERROR.
REQ-018 SHALL, in IDLE or ERROR, on req with req_sel >= NUM_CFG: set fail=1, stay in the current state, and issue no done pulse.
REQ-019 SHALL, in IDLE or ERROR, on a valid req with req_sel != cur_sel, or on any valid req from ERROR, on the next edge:
- latch cur_sel=req_sel;
- drive the dividers from cfg_table[req_sel] and pll_psda=req_phase;
- clear the retry count and fail;
- enter RST.
REQ-020 SHALL, in IDLE, on a valid req with req_sel == cur_sel:
- update pll_psda=req_phase on the next edge;
- enter PHASE with no PLL reset.
REQ-021 SHALL hold pll_reset=1 for exactly RST_CYCLES cycles in RST, then enter WAIT_LOCK with pll_reset=0.
REQ-022 SHALL, in WAIT_LOCK, move to IDLE once lock_s has been high for LOCK_STABLE consecutive cycles; on that edge locked=1 and done=1 for one cycle.
REQ-023 SHALL, when WAIT_LOCK reaches LOCK_TIMEOUT cycles, increment the retry count and re-enter RST if retry < MAX_RETRY; otherwise enter ERROR with fail=1, locked=0 and pll_reset=0.
REQ-024 SHALL, in PHASE, wait SETTLE cycles, then return to IDLE with a one-cycle done pulse; locked stays unchanged.
REQ-025 SHALL drive busy=1 in RST, WAIT_LOCK and PHASE, and 0 otherwise.
REQ-026 SHALL ignore req while busy=1; requests are not queued.
REQ-027 SHALL, in IDLE with locked=1, on lock_s falling to 0: clear locked and enter RST with the current config and a cleared retry count (auto-relock); no done pulse is issued until relock.
REQ-028 SHALL give a valid req priority over a lock loss occurring in the same cycle.
REQ-029 SHALL hold the divider and phase outputs constant except on the edges defined in REQ-019 and REQ-020.

Reset
REQ-030 SHALL, while reset=1, drive:
- state RST and cur_sel=0;
- dividers=cfg_table[0] and pll_psda=0;
- pll_reset=1 and busy=1;
- done=0, fail=0, locked=0;
- all counters cleared.
REQ-031 SHALL, on reset release, complete the RST_CYCLES pulse and bring up preset 0 with no req needed; reset asserted mid-operation aborts the operation immediately.

Verification
Test parameters: NUM_CFG=4, RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=4, SETTLE=8, MAX_RETRY=2.
REQ-032 SHALL cover power-up: release reset, raise pll_lock 10 cycles later -> pll_reset high for 4 cycles, then done and locked=1; cur_sel=0.
REQ-033 SHALL cover a preset switch: req with req_sel=2 and req_phase=5 while locked -> next cycle dividers=cfg_table[2], pll_psda=5, busy=1 and a 4-cycle pll_reset; done follows after lock.
REQ-034 SHALL cover phase-only: req with req_sel=cur_sel and req_phase=9 -> pll_psda=9 next cycle, no pll_reset, done after 8 cycles.
REQ-035 SHALL cover timeout: pll_lock held 0 -> two RST/WAIT_LOCK attempts of 20 cycles each, then ERROR with fail=1; a req with req_sel=1 then restarts and clears fail.
REQ-036 SHALL cover lock loss and bad index: drop pll_lock while IDLE -> locked=0 and automatic RST; req with req_sel=3 then 3 accepted; with NUM_CFG=3, req_sel=3 -> fail=1 and no state change.
